// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Default geometry plus the derivation of the occupancy-count width.
package reg_pipe_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_DEPTH     = 3;

  // Count must represent 0..depth inclusive.
  function automatic int pipe_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid+data register of the pipeline.
// Data is only overwritten by a valid word, so a bubble moving in keeps the old contents.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic                 ld,
  input  logic                 vin,
  input  logic [DATAWIDTH-1:0] din,
  output logic                 v,
  output logic [DATAWIDTH-1:0] d
);

  logic                 r_v;
  logic [DATAWIDTH-1:0] r_d;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (flush) begin
      r_v <= 1'b0;
    end else if (ld) begin
      r_v <= vin;
      if (vin) r_d <= din;
    end
  end

  assign v = r_v;
  assign d = r_d;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready on both sides,
// bubble collapse, synchronous flush and a registered occupancy count.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter  int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter  int DEPTH     = DEFAULT_DEPTH,
  localparam int CW        = pipe_cw(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [CW-1:0]        count
);

  logic [DEPTH-1:0]     w_v;
  logic [DATAWIDTH-1:0] w_d [DEPTH];
  logic [DEPTH-1:0]     w_rdy;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic [CW-1:0]        r_count;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic                 w_vin;
      logic [DATAWIDTH-1:0] w_din;

      // Flattened form of r[i] = !v[i] | r[i+1]: a stage can move unless it
      // and every stage downstream of it is full while the sink stalls.
      assign w_rdy[gi] = out_ready | ~(&w_v[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        assign w_vin = in_valid;
        assign w_din = in_data;
      end else begin : g_body
        assign w_vin = w_v[gi-1];
        assign w_din = w_d[gi-1];
      end

      reg_pipe_stage #(
        .DATAWIDTH(DATAWIDTH)
      ) u_stage (
        .Clk  (Clk),
        .Rst  (Rst),
        .flush(flush),
        .ld   (w_rdy[gi]),
        .vin  (w_vin),
        .din  (w_din),
        .v    (w_v[gi]),
        .d    (w_d[gi])
      );
    end
  endgenerate

  assign in_ready   = w_rdy[0] & ~flush;
  assign out_valid  = w_v[DEPTH-1];
  assign out_data   = w_d[DEPTH-1];
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready & ~flush;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + CW'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe (DATAWIDTH=8, DEPTH=3, 40 ns clock).
// Inputs change on the falling edge; transfers are predicted just before each rising edge.
module tb_reg_pipe;

  localparam int DW = 8;
  localparam int DEPTH = 3;
  localparam int CW = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] count;

  logic [DW-1:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  always #20 Clk = ~Clk;

  reg_pipe #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  // Predicts the transfers of the coming edge, runs the scoreboard, then
  // advances to the next falling edge.
  task automatic tick();
    logic ix, ox;
    logic [DW-1:0] exp_d;
    #1;
    ix = Rst & in_valid & in_ready;
    ox = Rst & out_valid & out_ready & !flush;
    if (ox) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_out: got unexpected word %0d, required none", out_data);
      end else begin
        exp_d = sb.pop_front();
        if (out_data !== exp_d) begin
          n_err++;
          $display("FAIL sb_out: got %0d, required %0d", out_data, exp_d);
        end else begin
          $display("out  %0d", out_data);
        end
      end
    end
    if (!Rst || flush) begin
      sb.delete();
    end else if (ix) begin
      sb.push_back(in_data);
      $display("in   %0d", in_data);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'd10; out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || count !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b d=%0d c=%0d, required 0/0/0", out_valid, out_data, count);
    end
    Rst = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got v=%0b c=%0d, required 0/0", out_valid, count);
    end
  endtask

  task automatic test_streaming();
    int exp_cnt [6] = '{1, 2, 3, 2, 1, 0};
    logic [DW-1:0] vals [3] = '{8'd10, 8'd20, 8'd30};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      in_data  = (i < 3) ? vals[i] : 8'd0;
      tick();
      n_cmp++;
      if (count !== CW'(exp_cnt[i])) begin
        n_err++;
        $display("FAIL stream_count[%0d]: got %0d, required %0d", i, count, exp_cnt[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_latency: out_valid got %0b, required 0 before third edge", out_valid);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'd10) begin
          n_err++;
          $display("FAIL stream_first: got v=%0b d=%0d, required 1/10", out_valid, out_data);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: %0d words missing, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    int idx = 0;
    logic acc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vals[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    #1;
    n_cmp++;
    if (idx != 3 || count !== CW'(3) || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: got accepted=%0d c=%0d rdy=%0b, required 3/3/0", idx, count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 0);
      in_data  = 8'd40;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_gap[%0d]: out_valid got %0b, required 1", i, out_valid);
      end
      tick();
    end
    n_cmp++;
    if (count !== '0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: got c=%0d pending=%0d, required 0/0", count, sb.size());
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd10; tick();
    in_valid = 1'b0;                  tick();
    in_valid = 1'b1; in_data = 8'd20; tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== CW'(2) || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_state: got c=%0d rdy=%0b, required 2/1", count, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'd10 || count !== CW'(2)) begin
      n_err++;
      $display("FAIL bubble_head: got v=%0b d=%0d c=%0d, required 1/10/2", out_valid, out_data, count);
    end
    in_valid = 1'b1; in_data = 8'd30; tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== CW'(3) || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bubble_fill: got c=%0d rdy=%0b, required 3/0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    n_cmp++;
    if (sb.size() != 0 || count !== '0) begin
      n_err++;
      $display("FAIL bubble_drain: got pending=%0d c=%0d, required 0/0", sb.size(), count);
    end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] vals [3] = '{8'd10, 8'd20, 8'd30};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i]; tick();
    end
    in_valid = 1'b1; in_data = 8'd50; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (count !== CW'(3) || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_ready: got c=%0d rdy=%0b, required 3/1", count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (count !== CW'(3)) begin
      n_err++;
      $display("FAIL full_count: got %0d, required 3", count);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    n_cmp++;
    if (sb.size() != 0 || count !== '0) begin
      n_err++;
      $display("FAIL full_drain: got pending=%0d c=%0d, required 0/0", sb.size(), count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'd70; tick();
    in_valid = 1'b1; in_data = 8'd80; tick();
    n_cmp++;
    if (count !== CW'(2)) begin
      n_err++;
      $display("FAIL flush_pre: count got %0d, required 2", count);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd60;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: got %0b, required 0", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: got c=%0d v=%0b, required 0/0", count, out_valid);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL flush_quiet: got v=%0b c=%0d, required 0/0", out_valid, count);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd90; tick();
    in_valid = 1'b1; in_data = 8'd91; tick();
    Rst = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = 8'd92;
    tick();
    Rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset: got c=%0d v=%0b d=%0d rdy=%0b, required 0/0/0/1",
               count, out_valid, out_data, in_ready);
    end
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_full_simul();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
